dmem_pipe_ctrl: RTL and testbench

Parametrised data-memory controller for the 64-bit RISC-V datapath. It replaces the single-cycle combinational data memory with a valid/ready request port, configurable read latency and a backpressurable response port. Byte-lane writes use the core's wmask convention. Misaligned and out-of-range accesses are flagged instead of silently wrapping. The block sits between the core's load/store unit and the on-chip word array.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_pipe_ctrl_sync_fifo.sv | 61 ++++++
 rtl/dmem_pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_dmem_pipe_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, helper function and response record for the data-memory controller.
package dmem_pkg;

    // Ceiling log2 for sizing indices and counters; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_DEPTH  = 512;
    localparam int BYTES       = DMEM_DATA_W / 8;
    localparam int OFF_W       = clog2(BYTES);
    localparam int IDX_W       = clog2(DMEM_DEPTH);

    // One response as seen by the load/store unit.
    typedef struct packed {
        logic                   we;
        logic                   err;
        logic [DMEM_DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/dmem_pipe_ctrl_sync_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers and an explicit occupancy count,
// so DEPTH need not be a power of two.
module sync_fifo
    import dmem_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 3,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_pop,
    output logic [W-1:0]     o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;
    logic             w_full;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_rdata = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wp] <= i_wdata;
    end

    // Pointers wrap at DEPTH-1; count tracks occupancy independently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= (r_wp == PTR_W'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (w_pop)  r_rp <= (r_rp == PTR_W'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // The owner must never push into a full queue unless it pops in the same cycle.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && w_full && !w_pop));

endmodule

// File: rtl/dmem_pipe_ctrl.sv
// Pipelined data-memory controller: valid/ready request port, fixed read
// latency, credit-limited response queue and access-error flagging.
module dmem_pipe_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = RD_LAT + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic                i_req_we,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wmask,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_rsp_we
);

    localparam int NB = DATA_W / 8;
    localparam int OW = clog2(NB);
    localparam int IW = clog2(DEPTH);
    localparam int HI = OW + IW;        // first address bit above the word index
    localparam int FW = DATA_W + 2;     // {we, err, data}
    localparam int PW = FW + 1;         // {valid, we, err, data}
    localparam int CW = clog2(RSP_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rst_d;
    logic [CW-1:0]     r_outst;

    logic              w_acc;
    logic [IW-1:0]     w_idx;
    logic              w_err;
    logic [DATA_W-1:0] w_rd;
    logic [PW-1:0]     w_s0;
    logic [PW-1:0]     w_tail;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [FW-1:0]     w_head;
    logic [CW-1:0]     w_cnt;

    // Accept only when a response slot is guaranteed; also held off for the
    // cycle after reset so the core sees a clean restart.
    assign o_req_ready = !i_rst && !r_rst_d && (r_outst < CW'(RSP_DEPTH));
    assign w_acc       = i_req_valid && o_req_ready;

    assign w_idx = i_req_addr[HI-1:OW];
    assign w_err = ((i_req_addr & ADDR_W'(NB - 1)) != '0) || ((i_req_addr >> HI) != '0);
    assign w_rd  = r_mem[w_idx];

    // Stage 0 is the accept cycle itself: the array is read combinationally,
    // so a read right after a write to the same word sees the new data.
    assign w_s0 = {w_acc, i_req_we, w_err, (i_req_we || w_err) ? '0 : w_rd};

    // Byte-masked write in the accept cycle; erroneous accesses leave the array alone.
    always_ff @(posedge i_clk) begin
        if (w_acc && i_req_we && !w_err) begin
            for (int b = 0; b < NB; b++) begin
                if (i_req_wmask[b]) r_mem[w_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
            end
        end
    end

    // Delayed reset flag extends req_ready low by one cycle.
    always_ff @(posedge i_clk) begin
        r_rst_d <= i_rst;
    end

    // Latency pipeline: RD_LAT-1 registered stages after stage 0, the FIFO
    // write being the final hop, so the response is visible RD_LAT cycles
    // after acceptance.
    if (RD_LAT == 1) begin : g_comb
        assign w_tail = w_s0;
    end else begin : g_pipe
        logic [PW-1:0] r_stg [1:RD_LAT-1];

        // Shift request records toward the queue; reset drops all in flight.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int k = 1; k < RD_LAT; k++) r_stg[k] <= '0;
            end else begin
                r_stg[1] <= w_s0;
                for (int k = 2; k < RD_LAT; k++) r_stg[k] <= r_stg[k-1];
            end
        end

        assign w_tail = r_stg[RD_LAT-1];
    end

    assign w_push = w_tail[PW-1] && !i_rst;
    assign w_pop  = o_rsp_valid && i_rsp_ready;

    sync_fifo #(
        .W     (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_tail[FW-1:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    assign o_rsp_valid = !w_empty && !i_rst;
    assign {o_rsp_we, o_rsp_err, o_rsp_rdata} = o_rsp_valid ? w_head : '0;

    // Credit counter: requests in the pipeline plus queued responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outst <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Credits bound both the total in flight and the queue occupancy.
    a_credit: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_outst <= CW'(RSP_DEPTH)) && (w_cnt <= r_outst));

endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// Directed bench for dmem_pipe_ctrl; three instances (RD_LAT 2, 1, 4) share stimulus.
module tb_dmem_pipe_ctrl;
    import dmem_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic        we;
        logic        err;
        logic [63:0] data;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_ready;

    logic        m_req_ready, m_rsp_valid, m_rsp_err, m_rsp_we;
    logic [63:0] m_rsp_rdata;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_we;
    logic [63:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_we;
    logic [63:0] b_rsp_rdata;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   acc_cyc;
    int   last_cyc;
    int   nrdy_bad = 0;
    logic tp_on = 1'b0;
    obs_t q_m[$], q_a[$], q_b[$];
    rsp_t q_exp[$];

    always #5 clk = ~clk;

    dmem_pipe_ctrl #(.RD_LAT(2)) u_m (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(m_req_ready),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
        .o_rsp_valid(m_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(m_rsp_rdata),
        .o_rsp_err(m_rsp_err), .o_rsp_we(m_rsp_we));

    dmem_pipe_ctrl #(.RD_LAT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(a_rsp_rdata),
        .o_rsp_err(a_rsp_err), .o_rsp_we(a_rsp_we));

    dmem_pipe_ctrl #(.RD_LAT(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(b_rsp_rdata),
        .o_rsp_err(b_rsp_err), .o_rsp_we(b_rsp_we));

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic obs_t mk(input int c, input logic we, input logic err, input logic [63:0] d);
        obs_t o;
        o.cyc = 32'(c); o.we = we; o.err = err; o.data = d;
        return o;
    endfunction

    // Record every response handshake with its cycle number.
    always @(negedge clk) begin
        if (!rst && rsp_ready) begin
            if (m_rsp_valid) q_m.push_back(mk(cyc_n, m_rsp_we, m_rsp_err, m_rsp_rdata));
            if (a_rsp_valid) q_a.push_back(mk(cyc_n, a_rsp_we, a_rsp_err, a_rsp_rdata));
            if (b_rsp_valid) q_b.push_back(mk(cyc_n, b_rsp_we, b_rsp_err, b_rsp_rdata));
        end
        if (tp_on && req_valid && (!a_req_ready || !b_req_ready)) nrdy_bad <= nrdy_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic err, input logic [63:0] d);
        rsp_t e;
        e.we = we; e.err = err; e.data = d;
        q_exp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one request and hold it until the RD_LAT=2 instance accepts it.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] wm);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wmask = wm;
        n = 0;
        @(negedge clk);
        while (!m_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!m_req_ready) chk("req_timeout", 64'(n), 64'(0));
        acc_cyc = cyc_n;
        tick();
        req_valid = 1'b0;
    endtask

    // Wait for n responses on the main instance and compare them in order.
    task automatic wait_rsp(input string tag, input int n);
        int   t;
        obs_t o;
        rsp_t e;
        t = 0;
        while (q_m.size() < n && t < 80) begin @(negedge clk); t++; end
        chk({tag, "_cnt"}, 64'(q_m.size()), 64'(n));
        for (int i = 0; i < n && q_m.size() > 0 && q_exp.size() > 0; i++) begin
            o = q_m.pop_front();
            e = q_exp.pop_front();
            chk($sformatf("%s%0d_we", tag, i), 64'(o.we), 64'(e.we));
            chk($sformatf("%s%0d_err", tag, i), 64'(o.err), 64'(e.err));
            chk($sformatf("%s%0d_data", tag, i), o.data, e.data);
            last_cyc = int'(o.cyc);
        end
        q_exp.delete();
        tick();
    endtask

    // Throughput stream: 16 reads on consecutive cycles starting at t0+lat.
    task automatic check_tp(input int which, input int lat, input int t0);
        obs_t o;
        int   sz;
        sz = (which == 0) ? q_m.size() : (which == 1) ? q_a.size() : q_b.size();
        chk($sformatf("tp%0d_cnt", which), 64'(sz), 64'(16));
        for (int i = 0; i < 16 && i < sz; i++) begin
            o = (which == 0) ? q_m[i] : (which == 1) ? q_a[i] : q_b[i];
            chk($sformatf("tp%0d_cyc%0d", which, i), 64'(o.cyc), 64'(t0 + lat + i));
            chk($sformatf("tp%0d_data%0d", which, i), o.data, 64'hA5A5_0000_0000_0000 | 64'(i));
        end
    endtask

    initial begin
        int n_acc;
        int nv;
        int t0;
        logic took;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", 64'(m_req_ready), 64'(0));
        chk("rst_valid", 64'(m_rsp_valid), 64'(0));
        chk("rst_rdata", m_rsp_rdata, 64'(0));
        chk("rst_err", 64'(m_rsp_err), 64'(0));
        chk("rst_we", 64'(m_rsp_we), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(m_req_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("ready_up", 64'(m_req_ready), 64'(1));
        tick();

        // Write then read of the same word on the next cycle
        do_req(1'b1, 32'h10, 64'h1122334455667788, 8'hFF); push_exp(1'b1, 1'b0, 64'h0);
        do_req(1'b0, 32'h10, 64'h0, 8'h00);
        t0 = acc_cyc;                                       push_exp(1'b0, 1'b0, 64'h1122334455667788);
        wait_rsp("wr_rd", 2);
        chk("rd_latency", 64'(last_cyc - t0), 64'(2));

        // Partial and no-op writes
        do_req(1'b1, 32'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF); push_exp(1'b1, 1'b0, 64'h0);
        do_req(1'b1, 32'h20, 64'h0, 8'h0F);                push_exp(1'b1, 1'b0, 64'h0);
        do_req(1'b0, 32'h20, 64'h0, 8'h00);                push_exp(1'b0, 1'b0, 64'hFFFFFFFF00000000);
        do_req(1'b1, 32'h20, 64'h1234, 8'h00);             push_exp(1'b1, 1'b0, 64'h0);
        do_req(1'b0, 32'h20, 64'h0, 8'h00);                push_exp(1'b0, 1'b0, 64'hFFFFFFFF00000000);
        wait_rsp("part", 5);

        // Misaligned and out-of-range accesses; last legal word still works
        do_req(1'b1, 32'h13, 64'hDEADDEADDEADDEAD, 8'hFF); push_exp(1'b1, 1'b1, 64'h0);
        do_req(1'b0, 32'h10, 64'h0, 8'h00);                push_exp(1'b0, 1'b0, 64'h1122334455667788);
        do_req(1'b0, 32'h0C, 64'h0, 8'h00);                push_exp(1'b0, 1'b1, 64'h0);
        do_req(1'b0, 32'h1000, 64'h0, 8'h00);              push_exp(1'b0, 1'b1, 64'h0);
        do_req(1'b1, 32'hFF8, 64'h0BADF00D00000FF8, 8'hFF); push_exp(1'b1, 1'b0, 64'h0);
        do_req(1'b0, 32'hFF8, 64'h0, 8'h00);               push_exp(1'b0, 1'b0, 64'h0BADF00D00000FF8);
        wait_rsp("err", 6);

        // Full boundary under backpressure
        do_req(1'b1, 32'h0, 64'hA0, 8'hFF); push_exp(1'b1, 1'b0, 64'h0);
        do_req(1'b1, 32'h8, 64'hA8, 8'hFF); push_exp(1'b1, 1'b0, 64'h0);
        wait_rsp("pre_full", 2);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_wmask = 8'h00;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            took = m_req_ready;
            tick();
            if (took) begin n_acc++; req_addr = req_addr + 32'h8; end
        end
        req_valid = 1'b0;
        push_exp(1'b0, 1'b0, 64'hA0);
        push_exp(1'b0, 1'b0, 64'hA8);
        push_exp(1'b0, 1'b0, 64'h1122334455667788);
        chk("full_accepts", 64'(n_acc), 64'(3));
        @(negedge clk);
        chk("full_ready", 64'(m_req_ready), 64'(0));
        chk("full_valid", 64'(m_rsp_valid), 64'(1));
        chk("full_head", m_rsp_rdata, 64'hA0);
        tick();
        @(negedge clk);
        chk("hold_head", m_rsp_rdata, 64'hA0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("pop_cycle_ready", 64'(m_req_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("after_pop_ready", 64'(m_req_ready), 64'(1));
        wait_rsp("drain", 3);

        // Reset while two reads are in flight
        do_req(1'b0, 32'h0, 64'h0, 8'h00);
        do_req(1'b0, 32'h8, 64'h0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 64'(m_req_ready), 64'(0));
        chk("mid_rst_valid", 64'(m_rsp_valid), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_ready", 64'(m_req_ready), 64'(0));
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m_rsp_valid) nv++;
        end
        chk("dropped_valid", 64'(nv), 64'(0));
        chk("dropped_q", 64'(q_m.size()), 64'(0));
        tick();
        do_req(1'b0, 32'h10, 64'h0, 8'h00); push_exp(1'b0, 1'b0, 64'h1122334455667788);
        wait_rsp("keep_mem", 1);

        // Throughput on all three latencies
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 32'h100 + 32'(8 * i), 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF);
            push_exp(1'b1, 1'b0, 64'h0);
        end
        wait_rsp("tp_wr", 16);
        repeat (8) tick();
        q_m.delete(); q_a.delete(); q_b.delete();
        tp_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 32'h100 + 32'(8 * i), 64'h0, 8'h00);
            if (i == 0) t0 = acc_cyc;
        end
        tp_on = 1'b0;
        chk("tp_last_accept", 64'(acc_cyc - t0), 64'(15));
        repeat (10) tick();
        chk("tp_all_ready", 64'(nrdy_bad), 64'(0));
        check_tp(0, 2, t0);
        check_tp(1, 1, t0);
        check_tp(2, 4, t0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
